// File: rtl/fwd_ctrl_if.sv
// fwd_ctrl_if: bundle of the hazard/forwarding controller's pipeline-facing signals.
//   ID-stage instruction fields : id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
//                                 id_regwrite, id_memtoreg, id_wreg
//   Pipeline events             : branch_taken, ext_stall
//   Controller results          : fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e, lu_count
// master: the pipeline side (drives instruction fields/events, consumes results).
// slave : the controller side.
interface fwd_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_regwrite;
    logic            id_memtoreg;
    logic [REGW-1:0] id_wreg;
    logic            branch_taken;
    logic            ext_stall;

    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            flush_e;
    logic [CNTW-1:0] lu_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_regwrite, id_memtoreg, id_wreg, branch_taken, ext_stall,
        input  fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e, lu_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_regwrite, id_memtoreg, id_wreg, branch_taken, ext_stall,
        output fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e, lu_count
    );
endinterface

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and hazard controller for a 5-stage in-order pipeline.
// Keeps shadow copies of the EX, MEM and WB instructions to select EX operand
// sources, detect load-use hazards, and resolve stall/flush priority.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - fwd_ctrl_if slave: ID instruction fields, branch_taken, ext_stall in;
//           fwd_a/fwd_b (00 regfile, 01 WB, 10 MEM), stall_f/stall_d,
//           flush_d/flush_e and the saturating load-use counter lu_count out.
module fwd_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input logic       clk,
    input logic       reset,
    fwd_ctrl_if.slave bus
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memtoreg;
        logic [REGW-1:0] wreg;
    } wr_entry_t;

    typedef struct packed {
        wr_entry_t       wr;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic            use_rs;
        logic            use_rt;
    } ex_entry_t;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_LOADUSE
    } action_e;

    ex_entry_t       ex_q, ex_d;
    wr_entry_t       mem_q, mem_d;
    wr_entry_t       wb_q, wb_d;
    logic [CNTW-1:0] lu_count_q, lu_count_d;

    logic            lu;
    action_e         act;

    // MEM wins over WB; a load still in MEM has no data yet, so it only
    // forwards once it reaches WB.
    function automatic logic [1:0] fwd_sel(input wr_entry_t       mem_e,
                                           input wr_entry_t       wb_e,
                                           input logic [REGW-1:0] src,
                                           input logic            use_src);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && mem_e.valid && mem_e.regwrite && !mem_e.memtoreg &&
            (mem_e.wreg != '0) && (mem_e.wreg == src)) begin
            sel = 2'b10;
        end else if (use_src && wb_e.valid && wb_e.regwrite &&
                     (wb_e.wreg != '0) && (wb_e.wreg == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        lu = bus.id_valid && ex_q.wr.valid && ex_q.wr.memtoreg && (ex_q.wr.wreg != '0) &&
             ((bus.id_use_rs && (bus.id_rs == ex_q.wr.wreg)) ||
              (bus.id_use_rt && (bus.id_rt == ex_q.wr.wreg)));

        // A taken branch outranks a load-use hazard: the ID instruction is wrong-path.
        if (bus.ext_stall) begin
            act = ACT_FREEZE;
        end else if (bus.branch_taken) begin
            act = ACT_FLUSH;
        end else if (lu) begin
            act = ACT_LOADUSE;
        end else begin
            act = ACT_NONE;
        end
    end

    always_comb begin
        bus.stall_f = 1'b0;
        bus.stall_d = 1'b0;
        bus.flush_d = 1'b0;
        bus.flush_e = 1'b0;
        unique case (act)
            ACT_FREEZE: begin
                bus.stall_f = 1'b1;
                bus.stall_d = 1'b1;
            end
            ACT_FLUSH: begin
                bus.flush_d = 1'b1;
                bus.flush_e = 1'b1;
            end
            ACT_LOADUSE: begin
                bus.stall_f = 1'b1;
                bus.stall_d = 1'b1;
                bus.flush_e = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.fwd_a    = fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.use_rs);
        bus.fwd_b    = fwd_sel(mem_q, wb_q, ex_q.rt, ex_q.use_rt);
        bus.lu_count = lu_count_q;
    end

    always_comb begin
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        lu_count_d = lu_count_q;

        if (!bus.ext_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q.wr;
            if ((act == ACT_FLUSH) || (act == ACT_LOADUSE)) begin
                // Bubble carries no source reads so it can never pick up forwarding.
                ex_d = '0;
            end else begin
                ex_d.wr.valid    = bus.id_valid;
                ex_d.wr.regwrite = bus.id_regwrite;
                ex_d.wr.memtoreg = bus.id_memtoreg;
                ex_d.wr.wreg     = bus.id_wreg;
                ex_d.rs          = bus.id_rs;
                ex_d.rt          = bus.id_rt;
                ex_d.use_rs      = bus.id_use_rs;
                ex_d.use_rt      = bus.id_use_rt;
            end
        end

        if ((act == ACT_LOADUSE) && (lu_count_q != '1)) begin
            lu_count_d = lu_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            lu_count_q <= '0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            lu_count_q <= lu_count_d;
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: table-driven directed bench for fwd_ctrl, plus hand sequences
// for counter saturation, reset during a stall and restart after reset.
module tb_fwd_ctrl;
    localparam int REGW = 5;
    localparam int CNTW = 3;
    localparam int CMAX = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fwd_ctrl_if #(.REGW(REGW), .CNTW(CNTW)) bus ();
    fwd_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    // ctl is {stall_f, stall_d, flush_d, flush_e}
    typedef struct {
        string nm;
        int v, rs, rt, urs, urt, rw, m2r, wd, br, xs;
        int ea, eb, ctl, cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input int ea, input int eb, input int ctl, input int cnt);
        chk({nm, ".fwd_a"}, int'(bus.fwd_a), ea);
        chk({nm, ".fwd_b"}, int'(bus.fwd_b), eb);
        chk({nm, ".ctl"}, int'({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e}), ctl);
        chk({nm, ".lu_count"}, int'(bus.lu_count), cnt);
    endtask

    task automatic drive_id(input int v, input int rs, input int rt, input int urs, input int urt,
                            input int rw, input int m2r, input int wd);
        bus.id_valid    = 1'(v);
        bus.id_rs       = REGW'(rs);
        bus.id_rt       = REGW'(rt);
        bus.id_use_rs   = 1'(urs);
        bus.id_use_rt   = 1'(urt);
        bus.id_regwrite = 1'(rw);
        bus.id_memtoreg = 1'(m2r);
        bus.id_wreg     = REGW'(wd);
    endtask

    function automatic vec_t mk(input string nm, input int v, input int rs, input int rt,
                                input int urs, input int urt, input int rw, input int m2r,
                                input int wd, input int br, input int xs, input int ea,
                                input int eb, input int ctl, input int cnt);
        vec_t r;
        r.nm = nm; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.rw = rw; r.m2r = m2r; r.wd = wd; r.br = br; r.xs = xs;
        r.ea = ea; r.eb = eb; r.ctl = ctl; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        int exp_cnt;

        //                nm            v rs rt us ut rw lm wd br xs  ea eb ctl     cnt
        vecs.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk("add_r3",     1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk("sub_r3",     1, 3, 1, 1, 1, 1, 0, 4, 0, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk("fwd_mem",    1, 3, 9, 1, 1, 1, 0, 8, 0, 0, 2, 0, 4'b0000, 0));
        vecs.push_back(mk("fwd_wb",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0));
        vecs.push_back(mk("lw_r5",      1, 1, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk("lu_stall",   1, 5, 5, 1, 1, 1, 0, 6, 0, 0, 0, 0, 4'b1101, 0));
        vecs.push_back(mk("lu_bubble",  1, 5, 5, 1, 1, 1, 0, 6, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("lu_wbfwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 1));
        vecs.push_back(mk("lw_r5_b",    1, 1, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("lu_branch",  1, 5, 5, 1, 1, 1, 0, 6, 1, 0, 0, 0, 4'b0011, 1));
        vecs.push_back(mk("br_nocount", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("add_r3_b",   1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("sub_r3r3",   1, 3, 3, 1, 1, 1, 0, 4, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("xs_1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4'b1100, 1));
        vecs.push_back(mk("xs_2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4'b1100, 1));
        vecs.push_back(mk("xs_3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4'b1100, 1));
        vecs.push_back(mk("xs_release", 1, 3, 4, 1, 1, 1, 0, 9, 0, 0, 2, 2, 4'b0000, 1));
        vecs.push_back(mk("wb_mem_mix", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4'b0000, 1));
        vecs.push_back(mk("add_r0_a",   1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("add_r0_b",   1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("read_r0",    1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("r0_nofwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("lw_r0",      1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("lw_r0_nolu", 1, 0, 0, 1, 1, 1, 0, 2, 0, 0, 1, 0, 4'b0000, 1));
        vecs.push_back(mk("add_r7_a",   1, 1, 2, 1, 1, 1, 0, 7, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("add_r7_b",   1, 1, 2, 1, 1, 1, 0, 7, 0, 0, 0, 2, 4'b0000, 1));
        vecs.push_back(mk("sub_r7r7",   1, 7, 7, 1, 1, 1, 0, 8, 0, 0, 0, 1, 4'b0000, 1));
        vecs.push_back(mk("mem_prio",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 4'b0000, 1));
        vecs.push_back(mk("lw_r9",      1, 1, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("inv_reader", 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("mem_ld_nof", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("tail",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));

        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.branch_taken = 1'b0;
        bus.ext_stall    = 1'b0;

        // Reset asserted before any clock edge must clear state on its own.
        #1 reset = 1'b0;
        #1 check_all("reset_async", 0, 0, 4'b0000, 0);
        @(negedge clk);
        check_all("reset_held", 0, 0, 4'b0000, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                     vecs[i].rw, vecs[i].m2r, vecs[i].wd);
            bus.branch_taken = 1'(vecs[i].br);
            bus.ext_stall    = 1'(vecs[i].xs);
            @(negedge clk);
            check_all(vecs[i].nm, vecs[i].ea, vecs[i].eb, vecs[i].ctl, vecs[i].cnt);
            @(posedge clk); #1;
        end
        bus.branch_taken = 1'b0;
        bus.ext_stall    = 1'b0;

        // Repeated load-use stalls (dependency through rt) drive the counter into saturation.
        exp_cnt = 1;
        for (int k = 0; k < 9; k++) begin
            drive_id(1, 1, 0, 1, 0, 1, 1, 5);
            @(posedge clk); #1;
            drive_id(1, 1, 5, 1, 1, 1, 0, 6);
            @(negedge clk);
            chk("sat_stall", int'(bus.stall_f), 1);
            chk("sat_cnt_pre", int'(bus.lu_count), exp_cnt);
            @(posedge clk); #1;
            exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
            drive_id(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("sat_cnt_post", int'(bus.lu_count), exp_cnt);
            @(posedge clk); #1;
        end

        // Reset mid-stall drops the stall immediately, without a clock edge.
        drive_id(1, 1, 0, 1, 0, 1, 1, 5);
        @(posedge clk); #1;
        drive_id(1, 1, 5, 1, 1, 1, 0, 6);
        @(negedge clk);
        check_all("pre_reset_stall", 0, 0, 4'b1101, CMAX);
        #2 reset = 1'b0;
        #1 check_all("reset_mid_stall", 0, 0, 4'b0000, 0);
        @(negedge clk);
        check_all("reset_clocked", 0, 0, 4'b0000, 0);

        // First edge after release shifts normally.
        reset = 1'b1;
        drive_id(1, 1, 2, 1, 1, 1, 0, 3);
        @(posedge clk); #1;
        drive_id(1, 3, 1, 1, 1, 1, 0, 4);
        @(posedge clk); #1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("post_reset_fwd", 2, 0, 4'b0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 SHALL have parameter REGW, default 5, meaning register-index width.
REQ-002 SHALL have parameter CNTW, default 16, meaning load-use counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  the ID stage holds a real instruction.
REQ-006 id_rs, id_rt  input  REGW each  source registers of the ID instruction.
REQ-007 id_use_rs, id_use_rt  input  1 each  the ID instruction reads rs / rt.
REQ-008 id_regwrite, id_memtoreg  input  1 each  the ID instruction writes a register / is a load.
REQ-009 id_wreg  input  REGW  destination register of the ID instruction.
REQ-010 branch_taken  input  1  the EX stage resolved a taken branch this cycle.
REQ-011 ext_stall  input  1  memory-side freeze of the whole pipeline.
REQ-012 fwd_a, fwd_b  output  2 each  EX operand select for the 3-input operand muxes: 00 = register-file value, 01 = WB result, 10 = MEM ALU result; 11 is never driven.
REQ-013 stall_f, stall_d  output  1 each  hold the PC / the IF-ID register.
REQ-014 flush_d, flush_e  output  1 each  clear the IF-ID register / insert a bubble into ID-EX.
REQ-015 lu_count  output  CNTW  saturating count of load-use stalls.

Function
REQ-016 The block SHALL hold internal EX, MEM and WB shadow entries {valid, regwrite, memtoreg, wreg}, plus rs, rt, use_rs and use_rt for EX.
REQ-017 When ext_stall=0, each rising edge SHALL shift WB<=MEM and MEM<=EX; EX<=bubble (valid=0) if flush_e=1, else EX<=ID fields with valid=id_valid.
REQ-018 When ext_stall=1, all shadow entries and lu_count SHALL hold.
REQ-019 fwd_a SHALL be 10 if the MEM entry is valid, has regwrite=1, has memtoreg=0, wreg!=0 and wreg==EX.rs with EX.use_rs=1.
REQ-020 Otherwise fwd_a SHALL be 01 if the WB entry is valid, has regwrite=1, wreg!=0 and wreg==EX.rs with EX.use_rs=1.
REQ-021 Otherwise fwd_a SHALL be 00; fwd_b follows REQ-019/020 using EX.rt and EX.use_rt; MEM has priority over WB.
REQ-022 Load-use hazard (lu) SHALL be: id_valid, and the EX entry is valid with memtoreg=1 and wreg!=0, and wreg matches a used id_rs or id_rt.
REQ-023 Outputs SHALL be combinational from shadow state and inputs, with this priority:
  - ext_stall=1: stall_f=stall_d=1, flush_d=flush_e=0.
  - else branch_taken=1: flush_d=flush_e=1, stall_f=stall_d=0; lu is ignored because the ID instruction is wrong-path.
  - else lu=1: stall_f=stall_d=1, flush_e=1, flush_d=0.
  - else all four are 0.
REQ-024 lu_count SHALL increment by 1 on each edge where the lu branch of REQ-023 was taken, and SHALL saturate at all-ones.
REQ-025 A load-use stall SHALL last exactly one cycle; on the next cycle the load is in MEM and the dependent instruction receives its data via WB forwarding (01) one cycle later.
REQ-026 Register 0 SHALL never cause forwarding or stalls.

Reset
REQ-027 While reset=0, all shadow valid bits SHALL be 0 and lu_count 0, independent of clk.
REQ-028 With reset=0, branch_taken=0 and ext_stall=0, all outputs SHALL be 0.
REQ-029 Reset asserted mid-stall SHALL drop stall_f/stall_d in the same cycle (no EX entry remains valid).
REQ-030 On the first edge after reset deasserts, normal shifting SHALL resume.

Verification
REQ-031 add r3 in ID, then sub using r3 next cycle -> sub in EX with fwd_a=10; one cycle later an instruction using r3 sees fwd_a=01.
REQ-032 lw r5, then add r6,r5,r5 in ID -> one cycle of stall_f=stall_d=flush_e=1 and lu_count 0->1; the next cycle shows fwd_a=fwd_b=01.
REQ-033 Same as REQ-032 but branch_taken=1 in the hazard cycle -> flush_d=flush_e=1, stall_f=stall_d=0, lu_count unchanged.
REQ-034 ext_stall=1 for 3 cycles during a forwarding window -> fwd values and shadow state frozen, stall_f/stall_d=1, flushes 0; afterwards forwarding resumes unchanged.
REQ-035 Writes to r0 from MEM and WB with EX reading r0 -> fwd_a=fwd_b=00, no stall.
REQ-036 Force lu_count near all-ones, then 3 load-use stalls -> count stays all-ones; assert reset=0 asynchronously -> count 0 and outputs 0 immediately.
